mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the single-port-per-direction synchronous data RAM (16-bit words, 8-bit address, 1-cycle registered read). It shares the RAM between port 0 (CPU load/store path) and port 1 (loader/debug path), granting at most one access per cycle with round-robin fairness and optional bounded burst locking. It also returns read data with a matching valid strobe. It sits between the CPU datapath/loader and the RAM instance in the top level.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 8, RAM address width
- MAX_BURST, 4, max consecutive locked grants to one port (≥1)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- pN_req  in  1  port N (N=0,1) access request
- pN_we  in  1  port N write (1) / read (0)
- pN_lock  in  1  port N requests to keep ownership after this access
- pN_addr  in  ADDR_WIDTH  port N address
- pN_wdata  in  DATA_WIDTH  port N write data
- pN_gnt  out  1  access accepted this cycle (combinational)
- pN_rvalid  out  1  read data for port N valid this cycle (registered)
- pN_rdata  out  DATA_WIDTH  read data (ram_dout passthrough; meaningful only with pN_rvalid)
- ram_read_address  out  ADDR_WIDTH  to RAM read_address
- ram_write_address  out  ADDR_WIDTH  to RAM write_address
- ram_write  out  1  to RAM write
- ram_din  out  DATA_WIDTH  to RAM din
- ram_dout  in  DATA_WIDTH  from RAM dout

## Operation
- Access transfers when pN_req & pN_gnt in the same cycle; requester holds req/we/addr/wdata stable until granted. Never both gnt high.
- Granted port's addr drives both ram_read_address and ram_write_address; ram_din = its wdata; ram_write = granted & we. With no grant: ram_write=0, addresses/din hold port 0 values (don't-care).
- State: IDLE, OWN0, OWN1; register last (last granted port, reset 1 so port 0 wins first tie); burst_cnt, width clog2(MAX_BURST+1), reset 0.
- IDLE: one requester → grant it; both → grant port ≠ last. If granted access has lock=1 and MAX_BURST>1 → OWNx with burst_cnt=1, else stay IDLE.
- OWNx, owner requesting: grant owner only; burst_cnt++. Return to IDLE if lock=0 or burst_cnt reaches MAX_BURST on this access; otherwise stay.
- OWNx, owner not requesting: lock breaks; arbitrate as IDLE this same cycle (other port may be granted); next state per IDLE rules.
- last updates to granted port on every grant; on MAX_BURST expiry other port therefore wins the next tie.
- Read accepted in cycle T → pN_rvalid=1 in T+1 only for that port; pN_rdata = ram_dout. Writes produce no rvalid.
- Write at A in T followed by read of A in T+1 returns new data (RAM write commits at end of T).

## Timing
- Grant: 0-cycle combinational from req and state. Read latency: 1 cycle (rvalid in T+1). Throughput: 1 access/cycle, back-to-back reads give consecutive rvalid.
- Reset (async assert): state=IDLE, last=1, burst_cnt=0, p0_rvalid=p1_rvalid=0; while reset_n=0 all gnt=0 and ram_write=0. Read accepted the cycle before reset is dropped (no rvalid).
- Deassertion: first grant possible in first cycle with reset_n=1.
- MAX_BURST=1: lock ignored; pure round-robin.

## Structure
- Shared package: state enum (IDLE/OWN0/OWN1), port index constants, default widths.
- Single module; optional sub-module rr_pick (2-way round-robin picker: req[1:0], last → grant[1:0]) reused in IDLE and lock-break paths.

## Test plan
- Reset: reset_n=0 with both req=1, we=1 → gnt=00, ram_write=0, rvalid=00; release → port 0 granted first cycle.
- Contention: both read continuously, no lock → grants alternate 0,1,0,1; rvalid follows grant by 1 cycle on correct port.
- Write-then-read: p0 write 0x00A5→addr 0x10 in T, p1 read 0x10 in T+1 → p1_rvalid in T+2 with rdata 0x00A5.
- Burst cap: p1 lock=1 continuously, p0 requesting, MAX_BURST=4 → p1 granted 4 consecutive cycles, then p0 granted, then p1.
- Lock break: p0 locks, then drops req one cycle while p1 requests → p1 granted that same cycle; state returns to IDLE.
- Mid-read reset: p0 read granted in T, reset_n low during T+1 → p0_rvalid=0, no spurious rvalid after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_MAX_BURST  = 4;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not served last.
module mem_arbiter_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Resolve a tie against the previously served port, otherwise pass the request through
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == PORT1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous data RAM between the CPU port (0) and the loader/debug port (1),
// with round-robin fairness, bounded burst locking and a one-cycle read-valid strobe.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic                  p0_lock,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic                  p1_lock,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int               CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_ONE   = CNT_W'(1);
    localparam logic             BURST_EN    = (MAX_BURST > 1);

    arb_state_t       state, state_next;
    logic             last, last_next;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_next, burst_inc;
    logic [1:0]       req, rr_grant, grant;
    logic             owner_busy, any_grant, sel, sel_we, sel_lock;

    assign req = {p1_req, p0_req};

    mem_arbiter_rr_pick u_rr_pick (
        .req   (req),
        .last  (last),
        .grant (rr_grant)
    );

    // Pick this cycle's winner: a requesting lock owner keeps the RAM, otherwise round-robin
    always_comb begin
        owner_busy = ((state == OWN0) && p0_req) || ((state == OWN1) && p1_req);
        grant      = rr_grant;
        if (owner_busy) begin
            grant = (state == OWN1) ? 2'b10 : 2'b01;
        end
        if (!reset_n) begin
            grant = 2'b00;
        end
        any_grant = |grant;
        sel       = grant[1];
        sel_we    = sel ? p1_we : p0_we;
        sel_lock  = sel ? p1_lock : p0_lock;
    end

    assign p0_gnt            = grant[0];
    assign p1_gnt            = grant[1];
    assign ram_read_address  = sel ? p1_addr : p0_addr;
    assign ram_write_address = sel ? p1_addr : p0_addr;
    assign ram_din           = sel ? p1_wdata : p0_wdata;
    assign ram_write         = any_grant & sel_we;
    assign p0_rdata          = ram_dout;
    assign p1_rdata          = ram_dout;

    // Decide ownership, burst count and fairness pointer after this cycle's grant
    always_comb begin
        state_next     = IDLE;
        last_next      = last;
        burst_cnt_next = '0;
        burst_inc      = burst_cnt + BURST_ONE;
        if (any_grant) begin
            last_next = sel;
            if (owner_busy) begin
                if (sel_lock && (burst_inc != BURST_LIMIT)) begin
                    state_next     = state;
                    burst_cnt_next = burst_inc;
                end
            end else if (sel_lock && BURST_EN) begin
                state_next     = sel ? OWN1 : OWN0;
                burst_cnt_next = BURST_ONE;
            end
        end
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last      <= PORT1;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    // Flag returning read data for the port whose read was accepted last cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= grant[0] & ~p0_we;
            p1_rvalid <= grant[1] & ~p1_we;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter and RAM.
module tb_mem_arbiter;

    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int MAXB = 4;

    typedef struct {
        logic          req;
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } port_t;

    bit            clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          req_a[2];
    logic          we_a[2];
    logic          lock_a[2];
    logic [AW-1:0] addr_a[2];
    logic [DW-1:0] wdata_a[2];
    port_t         stage[2];

    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_write;
    logic [DW-1:0] p0_rdata, p1_rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_read_address, ram_write_address;

    bit            ram_written[256];
    logic [DW-1:0] ram_mem[256];

    logic [DW-1:0] m_mem[256];
    int            m_owner;
    int            m_run;
    int            m_last;
    logic [1:0]    m_pv;
    logic [DW-1:0] m_pd[2];
    logic [1:0]    m_gnt;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .p0_req            (req_a[0]),
        .p0_we             (we_a[0]),
        .p0_lock           (lock_a[0]),
        .p0_addr           (addr_a[0]),
        .p0_wdata          (wdata_a[0]),
        .p0_gnt            (p0_gnt),
        .p0_rvalid         (p0_rvalid),
        .p0_rdata          (p0_rdata),
        .p1_req            (req_a[1]),
        .p1_we             (we_a[1]),
        .p1_lock           (lock_a[1]),
        .p1_addr           (addr_a[1]),
        .p1_wdata          (wdata_a[1]),
        .p1_gnt            (p1_gnt),
        .p1_rvalid         (p1_rvalid),
        .p1_rdata          (p1_rdata),
        .ram_read_address  (ram_read_address),
        .ram_write_address (ram_write_address),
        .ram_write         (ram_write),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout)
    );

    always #5 clk = ~clk;

    // Power-up contents of the RAM, shared by the RAM stand-in and the model
    function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
        return {a, ~a} ^ 16'h3C5A;
    endfunction

    // RAM stand-in: write commits at the clock edge, read data is registered
    always @(posedge clk) begin
        if (ram_write) begin
            ram_mem[ram_write_address]     <= ram_din;
            ram_written[ram_write_address] <= 1'b1;
        end
        ram_dout <= ram_written[ram_read_address] ? ram_mem[ram_read_address]
                                                  : initWord(ram_read_address);
    end

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic setPort(input int p, input logic req, input logic we, input logic lock,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        stage[p].req   = req;
        stage[p].we    = we;
        stage[p].lock  = lock;
        stage[p].addr  = addr;
        stage[p].wdata = wdata;
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance the model
    task automatic checkOutput();
        logic [1:0] req;
        int         g;
        logic       exp_w;
        req = {req_a[1], req_a[0]};
        if (!reset_n) begin
            compare("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'(2'b00));
            compare("rst_ram_write", 32'(ram_write), 32'(1'b0));
            compare("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'(2'b00));
            m_owner = -1;
            m_run   = 0;
            m_last  = 1;
            m_pv    = 2'b00;
            m_gnt   = 2'b00;
            return;
        end
        compare("p0_rvalid", 32'(p0_rvalid), 32'(m_pv[0]));
        compare("p1_rvalid", 32'(p1_rvalid), 32'(m_pv[1]));
        if (m_pv[0]) compare("p0_rdata", 32'(p0_rdata), 32'(m_pd[0]));
        if (m_pv[1]) compare("p1_rdata", 32'(p1_rdata), 32'(m_pd[1]));

        if (m_owner >= 0 && req[m_owner]) g = m_owner;
        else if (req == 2'b11)           g = 1 - m_last;
        else if (req[0])                 g = 0;
        else if (req[1])                 g = 1;
        else                             g = -1;

        m_gnt = (g == 1) ? 2'b10 : ((g == 0) ? 2'b01 : 2'b00);
        exp_w = 1'b0;
        if (g >= 0) exp_w = we_a[g];
        compare("gnt", 32'({p1_gnt, p0_gnt}), 32'(m_gnt));
        compare("ram_write", 32'(ram_write), 32'(exp_w));

        m_pv = 2'b00;
        if (g >= 0) begin
            compare("ram_read_address", 32'(ram_read_address), 32'(addr_a[g]));
            compare("ram_write_address", 32'(ram_write_address), 32'(addr_a[g]));
            if (we_a[g]) begin
                compare("ram_din", 32'(ram_din), 32'(wdata_a[g]));
                m_mem[addr_a[g]] = wdata_a[g];
            end else begin
                m_pv[g] = 1'b1;
                m_pd[g] = m_mem[addr_a[g]];
            end
            m_run   = (m_owner == g) ? m_run + 1 : 1;
            m_owner = (lock_a[g] && m_run < MAXB) ? g : -1;
            if (m_owner < 0) m_run = 0;
            m_last = g;
        end else begin
            m_owner = -1;
            m_run   = 0;
        end
    endtask

    // Present staged requests just after the clock edge and check mid-cycle
    task automatic applyStimulus(input logic rst_level);
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            req_a[p]   = stage[p].req;
            we_a[p]    = stage[p].we;
            lock_a[p]  = stage[p].lock;
            addr_a[p]  = stage[p].addr;
            wdata_a[p] = stage[p].wdata;
        end
        reset_n = rst_level;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic pinGnt(input string name, input logic [1:0] lit);
        compare({name, "_dut"}, 32'({p1_gnt, p0_gnt}), 32'(lit));
        compare({name, "_model"}, 32'(m_gnt), 32'(lit));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = initWord(AW'(i));
        for (int p = 0; p < 2; p++) begin
            setPort(p, 1'b0, 1'b0, 1'b0, '0, '0);
            req_a[p]   = 1'b0;
            we_a[p]    = 1'b0;
            lock_a[p]  = 1'b0;
            addr_a[p]  = '0;
            wdata_a[p] = '0;
            m_pd[p]    = '0;
        end
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        m_pv    = 2'b00;
        m_gnt   = 2'b00;
        #1 reset_n = 1'b0;

        // Reset holds off both writers
        setPort(0, 1'b1, 1'b1, 1'b0, 8'h05, 16'h1111);
        setPort(1, 1'b1, 1'b1, 1'b0, 8'h06, 16'h2222);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        pinGnt("reset", 2'b00);

        // Release with both reading: port 0 first, then strict alternation
        setPort(0, 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000);
        setPort(1, 1'b1, 1'b0, 1'b0, 8'h02, 16'h0000);
        applyStimulus(1'b1);
        pinGnt("release", 2'b01);
        applyStimulus(1'b1);
        pinGnt("rr1", 2'b10);
        compare("rr1_p0_rvalid", 32'(p0_rvalid), 32'(1'b1));
        compare("rr1_p0_rdata", 32'(p0_rdata), 32'(16'h01FE ^ 16'h3C5A));
        applyStimulus(1'b1);
        pinGnt("rr2", 2'b01);
        compare("rr2_p1_rvalid", 32'(p1_rvalid), 32'(1'b1));
        applyStimulus(1'b1);
        pinGnt("rr3", 2'b10);
        setPort(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        setPort(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(1'b1);

        // Write then immediate read of the same word
        setPort(0, 1'b1, 1'b1, 1'b0, 8'h10, 16'h00A5);
        applyStimulus(1'b1);
        setPort(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        setPort(1, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
        applyStimulus(1'b1);
        setPort(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(1'b1);
        compare("wr_rd_valid", 32'(p1_rvalid), 32'(1'b1));
        compare("wr_rd_data", 32'(p1_rdata), 32'(16'h00A5));

        // Burst cap: locked port 1 gets four in a row, then port 0, then port 1 again
        setPort(1, 1'b1, 1'b0, 1'b1, 8'h20, 16'h0000);
        applyStimulus(1'b1);
        pinGnt("burst1", 2'b10);
        setPort(0, 1'b1, 1'b0, 1'b0, 8'h21, 16'h0000);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(1'b1);
            pinGnt("burst_own", 2'b10);
        end
        applyStimulus(1'b1);
        pinGnt("burst_cap", 2'b01);
        setPort(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(1'b1);
        pinGnt("burst_after", 2'b10);
        setPort(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(1'b1);
        applyStimulus(1'b1);

        // Lock break: owner drops its request and the other port is served that cycle
        setPort(0, 1'b1, 1'b0, 1'b1, 8'h30, 16'h0000);
        applyStimulus(1'b1);
        pinGnt("lock_take", 2'b01);
        setPort(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        setPort(1, 1'b1, 1'b0, 1'b0, 8'h31, 16'h0000);
        applyStimulus(1'b1);
        pinGnt("lock_break", 2'b10);
        setPort(0, 1'b1, 1'b0, 1'b0, 8'h32, 16'h0000);
        applyStimulus(1'b1);
        pinGnt("lock_idle", 2'b01);
        setPort(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        setPort(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(1'b1);

        // Reset lands between a read grant and its data strobe
        setPort(0, 1'b1, 1'b0, 1'b0, 8'h40, 16'h0000);
        applyStimulus(1'b1);
        pinGnt("midrst_read", 2'b01);
        setPort(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(1'b0);
        compare("midrst_p0_rvalid", 32'(p0_rvalid), 32'(1'b0));
        applyStimulus(1'b1);
        compare("midrst_after_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'(2'b00));
        applyStimulus(1'b1);

        // Randomized traffic: requests held until granted, occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!stage[p].req || m_gnt[p]) begin
                    stage[p].req   = ($urandom_range(0, 99) < 65);
                    stage[p].we    = 1'($urandom_range(0, 1));
                    stage[p].lock  = ($urandom_range(0, 3) != 0);
                    stage[p].addr  = AW'($urandom_range(0, 15));
                    stage[p].wdata = DW'($urandom);
                end
            end
            applyStimulus(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
